// File: rtl/cnt_seq_monitor_if.sv
// Bus between the upstream counter's consumer-side controls and cnt_seq_monitor.
// master drives enable/clear/counter value; slave (the monitor) returns status.
interface cnt_seq_monitor_if #(
    parameter int unsigned WRAP_W = 8,
    parameter int unsigned ERR_W  = 4
);
    logic              en;
    logic              clr;
    logic [2:0]        cnt_in;
    logic              tc_pulse;
    logic              locked;
    logic              seq_err;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [ERR_W-1:0]  err_cnt;
    logic [2:0]        last_cnt;

    modport master (
        output en, clr, cnt_in,
        input  tc_pulse, locked, seq_err, wrap_cnt, err_cnt, last_cnt
    );

    modport slave (
        input  en, clr, cnt_in,
        output tc_pulse, locked, seq_err, wrap_cnt, err_cnt, last_cnt
    );
endinterface

// File: rtl/cnt_seq_monitor.sv
// Checks that a 3-bit counter advances by +1 mod 8 each cycle; reports lock,
// terminal-count pulses, saturating wrap/error counts and a sticky error flag.
module cnt_seq_monitor #(
    parameter int unsigned LOCK_N     = 4,
    parameter int unsigned ALLOW_HOLD = 0,
    parameter int unsigned WRAP_W     = 8,
    parameter int unsigned ERR_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    cnt_seq_monitor_if.slave         bus
);
    localparam int unsigned RUN_W   = 4;
    localparam bit          HOLD_OK = (ALLOW_HOLD != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        prev;
    logic              prev_valid;
    logic [RUN_W-1:0]  run;
    logic              tc_pulse_q;
    logic              locked_q;
    logic              seq_err_q;
    logic [WRAP_W-1:0] wrap_cnt_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [2:0]        last_cnt_q;

    logic              step_c;
    logic              inc_c;
    logic              bad_c;
    logic              wrap_evt_c;
    logic              err_evt_c;
    logic [RUN_W-1:0]  run_nxt_c;

    // Step classification against the previous sample
    always_comb begin
        step_c     = bus.en && prev_valid && (state != S_IDLE);
        inc_c      = (bus.cnt_in == 3'(prev + 3'd1));
        bad_c      = !inc_c && !(HOLD_OK && (bus.cnt_in == prev));
        wrap_evt_c = step_c && inc_c && (prev == 3'd7);
        err_evt_c  = step_c && bad_c && (state == S_LOCKED);
        run_nxt_c  = run + RUN_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            prev       <= 3'd0;
            prev_valid <= 1'b0;
            run        <= '0;
            tc_pulse_q <= 1'b0;
            locked_q   <= 1'b0;
            seq_err_q  <= 1'b0;
            wrap_cnt_q <= '0;
            err_cnt_q  <= '0;
            last_cnt_q <= 3'd0;
        end else begin
            tc_pulse_q <= wrap_evt_c;

            if (bus.en) begin
                prev       <= bus.cnt_in;
                last_cnt_q <= bus.cnt_in;
            end

            if (!bus.en) begin
                state      <= S_IDLE;
                prev_valid <= 1'b0;
                locked_q   <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        prev_valid <= 1'b1;
                        run        <= '0;
                        state      <= S_ACQ;
                    end
                    S_ACQ: begin
                        if (inc_c) begin
                            run <= run_nxt_c;
                            if (run_nxt_c == RUN_W'(LOCK_N)) begin
                                state    <= S_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else if (bad_c) begin
                            run <= '0;
                        end
                    end
                    S_LOCKED: begin
                        if (bad_c) begin
                            run      <= '0;
                            state    <= S_ACQ;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end

            // Status counters: clear beats a same-edge event
            if (bus.clr) begin
                wrap_cnt_q <= '0;
                err_cnt_q  <= '0;
                seq_err_q  <= 1'b0;
            end else begin
                if (wrap_evt_c && (wrap_cnt_q != '1))
                    wrap_cnt_q <= wrap_cnt_q + WRAP_W'(1);
                if (err_evt_c) begin
                    seq_err_q <= 1'b1;
                    if (err_cnt_q != '1)
                        err_cnt_q <= err_cnt_q + ERR_W'(1);
                end
            end
        end
    end

    assign bus.tc_pulse = tc_pulse_q;
    assign bus.locked   = locked_q;
    assign bus.seq_err  = seq_err_q;
    assign bus.wrap_cnt = wrap_cnt_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.last_cnt = last_cnt_q;
endmodule

// File: tb/tb_cnt_seq_monitor.sv
// Directed bench for cnt_seq_monitor: instance A (no hold, 5-bit wrap count)
// and instance B (hold allowed) receive identical stimulus.
module tb_cnt_seq_monitor;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   tcs;

    cnt_seq_monitor_if #(.WRAP_W(5), .ERR_W(4)) ifa ();
    cnt_seq_monitor_if #(.WRAP_W(5), .ERR_W(4)) ifb ();

    cnt_seq_monitor #(.LOCK_N(4), .ALLOW_HOLD(0), .WRAP_W(5), .ERR_W(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    cnt_seq_monitor #(.LOCK_N(4), .ALLOW_HOLD(1), .WRAP_W(5), .ERR_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive like the upstream counter (on negedge), then sample 1 time unit after posedge
    task automatic step(input logic e, input logic c, input logic [2:0] v);
        @(negedge clk);
        ifa.en = e; ifa.clr = c; ifa.cnt_in = v;
        ifb.en = e; ifb.clr = c; ifb.cnt_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic lk, input logic tc,
                         input logic se, input int wr, input int er);
        chk({tag, ".locked"},   32'(ifa.locked),   32'(lk));
        chk({tag, ".tc_pulse"}, 32'(ifa.tc_pulse), 32'(tc));
        chk({tag, ".seq_err"},  32'(ifa.seq_err),  32'(se));
        chk({tag, ".wrap_cnt"}, 32'(ifa.wrap_cnt), 32'(wr));
        chk({tag, ".err_cnt"},  32'(ifa.err_cnt),  32'(er));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        ifa.en = 1'b0; ifa.clr = 1'b0; ifa.cnt_in = 3'd0;
        ifb.en = 1'b0; ifb.clr = 1'b0; ifb.cnt_in = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_a("reset", 1'b0, 1'b0, 1'b0, 0, 0);
        chk("reset.last_cnt", 32'(ifa.last_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Acquire: 0 captures, 1..4 are four increments
        step(1'b1, 1'b0, 3'd0);
        chk_a("acq0", 1'b0, 1'b0, 1'b0, 0, 0);
        chk("acq0.last_cnt", 32'(ifa.last_cnt), 32'd0);
        step(1'b1, 1'b0, 3'd1);
        step(1'b1, 1'b0, 3'd2);
        step(1'b1, 1'b0, 3'd3);
        chk_a("acq3", 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 3'd4);
        chk_a("lock4", 1'b1, 1'b0, 1'b0, 0, 0);

        // Wrap while locked
        step(1'b1, 1'b0, 3'd5);
        step(1'b1, 1'b0, 3'd6);
        step(1'b1, 1'b0, 3'd7);
        chk_a("pre_wrap", 1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 3'd0);
        chk_a("wrap1", 1'b1, 1'b1, 1'b0, 1, 0);
        step(1'b1, 1'b0, 3'd1);
        chk_a("post_wrap1", 1'b1, 1'b0, 1'b0, 1, 0);

        // Skip 3->5 while locked
        step(1'b1, 1'b0, 3'd2);
        step(1'b1, 1'b0, 3'd3);
        step(1'b1, 1'b0, 3'd5);
        chk_a("skip", 1'b0, 1'b0, 1'b1, 1, 1);
        chk("skip.last_cnt", 32'(ifa.last_cnt), 32'd5);
        step(1'b1, 1'b0, 3'd6);
        step(1'b1, 1'b0, 3'd7);
        step(1'b1, 1'b0, 3'd0);
        chk_a("reacq_wrap", 1'b0, 1'b1, 1'b1, 2, 1);
        step(1'b1, 1'b0, 3'd1);
        chk_a("relock", 1'b1, 1'b0, 1'b1, 2, 1);

        // Repeated value: error for A, legal hold for B
        step(1'b1, 1'b0, 3'd2);
        step(1'b1, 1'b0, 3'd2);
        chk_a("hold_a", 1'b0, 1'b0, 1'b1, 2, 2);
        chk("hold_b.locked",  32'(ifb.locked),  32'd1);
        chk("hold_b.err_cnt", 32'(ifb.err_cnt), 32'd1);
        step(1'b1, 1'b0, 3'd3);
        step(1'b1, 1'b0, 3'd4);
        step(1'b1, 1'b0, 3'd5);
        chk("hold_a_acq.locked", 32'(ifa.locked), 32'd0);
        chk("hold_b_run.locked", 32'(ifb.locked), 32'd1);
        step(1'b1, 1'b0, 3'd6);
        chk_a("hold_relock", 1'b1, 1'b0, 1'b1, 2, 2);
        chk("hold_b2.err_cnt", 32'(ifb.err_cnt), 32'd1);

        // 40 more wraps saturate the 5-bit wrap counter
        tcs = 0;
        for (int i = 0; i < 40 * 8; i++) begin
            step(1'b1, 1'b0, 3'((i + 7) % 8));
            if (ifa.tc_pulse) tcs++;
        end
        chk("sat.tc_count", 32'(tcs), 32'd40);
        chk_a("sat", 1'b1, 1'b0, 1'b1, 31, 2);

        // Clear coincident with a wrap
        step(1'b1, 1'b0, 3'd7);
        step(1'b1, 1'b1, 3'd0);
        chk_a("clr_wrap", 1'b1, 1'b1, 1'b0, 0, 0);
        for (int v = 1; v < 8; v++) step(1'b1, 1'b0, 3'(v));
        step(1'b1, 1'b0, 3'd0);
        chk_a("wrap_after_clr", 1'b1, 1'b1, 1'b0, 1, 0);

        // Disable: unlock, counters and last_cnt held
        step(1'b0, 1'b0, 3'd7);
        chk_a("disable", 1'b0, 1'b0, 1'b0, 1, 0);
        chk("disable.last_cnt", 32'(ifa.last_cnt), 32'd0);
        // First sample after IDLE never pulses even if it follows 7
        step(1'b1, 1'b0, 3'd0);
        chk_a("reen0", 1'b0, 1'b0, 1'b0, 1, 0);
        step(1'b1, 1'b0, 3'd1);
        step(1'b1, 1'b0, 3'd2);
        step(1'b1, 1'b0, 3'd3);
        step(1'b1, 1'b0, 3'd4);
        chk_a("reen_lock", 1'b1, 1'b0, 1'b0, 1, 0);
        step(1'b1, 1'b0, 3'd6);
        step(1'b1, 1'b0, 3'd7);
        step(1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 3'd1);
        step(1'b1, 1'b0, 3'd2);
        chk_a("pre_rst", 1'b1, 1'b0, 1'b1, 2, 1);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b0;
        ifa.en = 1'b0; ifb.en = 1'b0;
        #1;
        chk_a("async_rst", 1'b0, 1'b0, 1'b0, 0, 0);
        chk("async_rst.last_cnt", 32'(ifa.last_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 3'd1);
        step(1'b1, 1'b0, 3'd2);
        chk_a("post_rst_run2", 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 3'd3);
        chk("post_rst_run3.locked", 32'(ifa.locked), 32'd0);
        step(1'b1, 1'b0, 3'd4);
        chk("post_rst_lock.locked", 32'(ifa.locked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
